// File: rtl/ripple_count_ctrl.sv
// ripple_count_ctrl
//   Run controller for a WIDTH-bit T-flip-flop ripple counter. A run clears
//   the counter, enables it for exactly `target` clock edges (pause stretches
//   the run without losing counts), waits for the ripple to settle, samples q
//   and compares it against a synchronous shadow count.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   begin a run (accepted in IDLE only)
//   target     in   number of counts for the run, latched on start
//   pause      in   level, suspends counting
//   abort      in   level, ends any run without done
//   q          in   ripple counter output
//   T          out  counter toggle enable (registered)
//   ctr_reset  out  counter clear (registered, active-high)
//   busy       out  high whenever not IDLE
//   done       out  one-cycle pulse when count/error are valid
//   count      out  sampled q, held until the next done
//   error      out  sticky q/shadow mismatch, cleared on start
//
// state   | meaning
// IDLE    | waiting for start, counter outputs quiet
// CLEAR   | ctr_reset held high for CLR_CYCLES cycles
// RUN     | T high, one counter increment per edge
// PAUSED  | T low while pause is held, shadow holds
// SETTLE  | T low for SETTLE cycles, then q is sampled

module ripple_count_ctrl #(
  parameter int WIDTH      = 5,
  parameter int CLR_CYCLES = 2,
  parameter int SETTLE     = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] q,
  output logic             T,
  output logic             ctr_reset,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count,
  output logic             error
);

  localparam int TMR_MAX = (CLR_CYCLES > SETTLE) ? CLR_CYCLES : SETTLE;
  localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TW-1:0] CLR_LOAD    = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [TW-1:0]    r_tmr;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_shadow;
  logic             r_t;
  logic             r_ctr_reset;
  logic             r_done;
  logic [WIDTH-1:0] r_count;
  logic             r_error;

  logic             w_tc;
  logic             w_abort;
  logic [WIDTH-1:0] w_shadow_inc;
  logic             w_last;

  // Shared down-counter for CLEAR and SETTLE; terminal count marks the last edge.
  assign w_tc         = (r_tmr == '0);
  assign w_abort      = abort && (r_state != S_IDLE);
  assign w_shadow_inc = r_shadow + WIDTH'(1);
  assign w_last       = (w_shadow_inc == r_target);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_CLEAR;
      S_CLEAR:  if (w_tc) w_next = (r_target != '0) ? S_RUN : S_SETTLE;
      // Reaching target wins over pause so the final edge always goes to SETTLE.
      S_RUN:    if (w_last) w_next = S_SETTLE;
                else if (pause) w_next = S_PAUSED;
      S_PAUSED: if (!pause) w_next = S_RUN;
      S_SETTLE: if (w_tc) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Registered outputs, timer, shadow count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tmr       <= '0;
      r_target    <= '0;
      r_shadow    <= '0;
      r_t         <= 1'b0;
      r_ctr_reset <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_t         <= 1'b0;
        r_ctr_reset <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_t         <= 1'b0;
            r_ctr_reset <= 1'b0;
            if (start) begin
              r_target    <= target;
              r_shadow    <= '0;
              r_error     <= 1'b0;
              r_ctr_reset <= 1'b1;
              r_tmr       <= CLR_LOAD;
            end
          end
          S_CLEAR: begin
            if (w_tc) begin
              r_ctr_reset <= 1'b0;
              r_t         <= (r_target != '0);
              r_tmr       <= SETTLE_LOAD;
            end else begin
              r_tmr <= r_tmr - TW'(1);
            end
          end
          S_RUN: begin
            // T is high throughout RUN, so every edge here is a counter increment.
            r_shadow <= w_shadow_inc;
            if (w_last) begin
              r_t   <= 1'b0;
              r_tmr <= SETTLE_LOAD;
            end else if (pause) begin
              r_t <= 1'b0;
            end
          end
          S_PAUSED: begin
            if (!pause) r_t <= 1'b1;
          end
          S_SETTLE: begin
            if (w_tc) begin
              r_count <= q;
              r_error <= (q != r_shadow);
              r_done  <= 1'b1;
            end else begin
              r_tmr <= r_tmr - TW'(1);
            end
          end
          default: begin
            r_t         <= 1'b0;
            r_ctr_reset <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output logic
  always_comb begin
    busy      = (r_state != S_IDLE);
    T         = r_t;
    ctr_reset = r_ctr_reset;
    done      = r_done;
    count     = r_count;
    error     = r_error;
  end

endmodule

// File: tb/tb_ripple_count_ctrl.sv
module tb_ripple_count_ctrl;
  localparam int W = 5;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] target;
  logic         pause;
  logic         abort;
  logic [W-1:0] q;
  logic         T;
  logic         ctr_reset;
  logic         busy;
  logic         done;
  logic [W-1:0] count;
  logic         error;

  ripple_count_ctrl #(.WIDTH(W), .CLR_CYCLES(2), .SETTLE(3)) dut (
    .clock(clock), .reset(reset), .start(start), .target(target),
    .pause(pause), .abort(abort), .q(q), .T(T), .ctr_reset(ctr_reset),
    .busy(busy), .done(done), .count(count), .error(error)
  );

  always #5 clock = ~clock;

  // Counter model: cleared by ctr_reset, increments on T; can drop one increment.
  logic [W-1:0] qm = '0;
  logic         drop_req = 1'b0;
  logic         drop_done = 1'b0;
  always @(posedge clock) begin
    if (ctr_reset) begin
      qm        <= '0;
      drop_done <= 1'b0;
    end else if (T) begin
      if (drop_req && !drop_done) drop_done <= 1'b1;
      else                        qm <= qm + 1'b1;
    end
  end
  assign q = qm;

  // Edge bookkeeping
  int   cyc = 0, t_edges = 0, clr_edges = 0;
  int   last_t_cyc = 0, first_t_cyc = 0, start_cyc = 0;
  logic t_prev = 1'b0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (T) begin
      t_edges    <= t_edges + 1;
      last_t_cyc <= cyc + 1;
      if (!t_prev) first_t_cyc <= cyc + 1;
    end
    t_prev <= T;
    if (ctr_reset) clr_edges <= clr_edges + 1;
    if (start && !busy && !reset) start_cyc <= cyc + 1;
  end

  typedef struct packed {
    logic [W-1:0] c;
    logic         e;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_pop;

  int n_checks = 0, n_errors = 0;
  int done_cnt = 0, done_cyc = 0;
  int t0, c0, d0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_start(input int tgt);
    @(negedge clock);
    start  = 1'b1;
    target = W'(tgt);
    @(negedge clock);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check(name, 0, 1);
      exp_q.delete();
    end
    @(negedge clock);
    #1;
  endtask

  task automatic wait_edges(input string name, input int base, input int n);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (t_edges - base >= n) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check(name, t_edges - base, n);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    pause  = 1'b0;
    abort  = 1'b0;
    target = '0;

    fork
      forever begin
        @(negedge clock);
        if (!reset && done) begin
          done_cnt++;
          done_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected_done count=%0d required=no_done", count);
          end else begin
            e_pop = exp_q.pop_front();
            check("sb_count", int'(count), int'(e_pop.c));
            check("sb_error", int'(error), int'(e_pop.e));
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
      end
    join_none

    #2;
    check("rst_T", T, 0);
    check("rst_ctr_reset", ctr_reset, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_error", error, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // target=10, no pause
    t0 = t_edges; c0 = clr_edges;
    exp_q.push_back('{c: 5'd10, e: 1'b0});
    do_start(10);
    wait_done("t1_done_timeout", 100);
    check("t1_t_edges", t_edges - t0, 10);
    check("t1_clr_cycles", clr_edges - c0, 2);
    check("t1_start_to_first_t", first_t_cyc - start_cyc, 3);
    check("t1_last_t_to_done", done_cyc - last_t_cyc, 3);
    check("t1_busy_after", busy, 0);

    // target=20 with a 5-cycle pause after the 4th enabled edge
    t0 = t_edges;
    exp_q.push_back('{c: 5'd20, e: 1'b0});
    do_start(20);
    wait_edges("t2_reach4", t0, 4);
    pause = 1'b1;
    @(negedge clock);
    check("t2_pause_T", T, 0);
    check("t2_pause_edges", t_edges - t0, 5);
    repeat (3) @(negedge clock);
    check("t2_pause_T_hold", T, 0);
    check("t2_pause_busy", busy, 1);
    @(negedge clock);
    pause = 1'b0;
    wait_done("t2_done_timeout", 100);
    check("t2_t_edges", t_edges - t0, 20);

    // target=0: no counting, done 6 edges after start (start edge inclusive)
    t0 = t_edges;
    exp_q.push_back('{c: 5'd0, e: 1'b0});
    do_start(0);
    wait_done("t3_done_timeout", 50);
    check("t3_t_edges", t_edges - t0, 0);
    check("t3_start_to_done", done_cyc - start_cyc, 5);

    // target=31 (max)
    t0 = t_edges;
    exp_q.push_back('{c: 5'd31, e: 1'b0});
    do_start(31);
    wait_done("t4_done_timeout", 100);
    check("t4_t_edges", t_edges - t0, 31);

    // counter drops one increment: q=11 vs shadow 12
    drop_req = 1'b1;
    exp_q.push_back('{c: 5'd11, e: 1'b1});
    do_start(12);
    wait_done("t4b_done_timeout", 100);
    drop_req = 1'b0;
    check("t4b_error_sticky", error, 1);
    exp_q.push_back('{c: 5'd3, e: 1'b0});
    do_start(3);
    check("t4c_error_cleared", error, 0);
    wait_done("t4c_done_timeout", 50);

    // abort at the 6th enabled edge of a target=15 run; stray start ignored
    d0 = done_cnt; t0 = t_edges;
    do_start(15);
    wait_edges("t5_reach2", t0, 2);
    start  = 1'b1;
    target = 5'd3;
    @(negedge clock);
    start  = 1'b0;
    wait_edges("t5_reach5", t0, 5);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("t5_abort_T", T, 0);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_edges", t_edges - t0, 6);
    repeat (20) @(negedge clock);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_count_kept", count, 3);
    check("t5_error_kept", error, 0);
    check("t5_T_quiet", t_edges - t0, 6);

    // async reset between edges mid-RUN, then a clean target=7 run
    t0 = t_edges;
    do_start(15);
    wait_edges("t6_reach3", t0, 3);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_T", T, 0);
    check("t6_rst_ctr_reset", ctr_reset, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", count, 0);
    @(negedge clock);
    reset = 1'b0;
    t0 = t_edges;
    exp_q.push_back('{c: 5'd7, e: 1'b0});
    do_start(7);
    wait_done("t6_done_timeout", 50);
    check("t6_t_edges", t_edges - t0, 7);

    repeat (3) @(negedge clock);
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ripple_count_ctrl.md
Name: ripple_count_ctrl

Overview:
Run controller for the WIDTH-bit T-flip-flop ripple counter. On a start command it clears the counter, enables it for exactly `target` clock edges, and honours pause and abort requests. After the counter's ripple has settled it samples the counter output and reports the final count. It also flags an error when the sampled value differs from an internal synchronous shadow count. It sits between the command source (bench or host logic) and the counter's T/reset inputs.

Parameters:
WIDTH, 5, counter width in bits
CLR_CYCLES, 2, cycles ctr_reset is held high before counting (min 1)
SETTLE, 3, idle cycles after the last enabled edge before sampling q (min 1)

Ports:
clock  input  1  single system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a run; sampled only in IDLE
target  input  WIDTH  number of counts to run; latched when start is accepted
pause  input  1  level; while high, counting is suspended
abort  input  1  level; terminates any run, no done
q  input  WIDTH  ripple counter output (asynchronous, settles after ripple delay)
T  output  1  counter toggle enable, registered
ctr_reset  output  1  counter clear, registered, active-high
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when the result is valid
count  output  WIDTH  q sampled at end of run; holds until next done
error  output  1  sticky mismatch flag; cleared when start is accepted

Behaviour:
- Reset (async, immediate, no clock needed): state=IDLE, T=0, ctr_reset=0, done=0, count=0, error=0, shadow=0, all internal counters=0.
- States: IDLE, CLEAR, RUN, PAUSED, SETTLE.
- IDLE: T=0, ctr_reset=0. A start=1 edge latches target, sets shadow=0 and error=0, sets ctr_reset<=1, and enters CLEAR. start in any other state is ignored.
- CLEAR: ctr_reset stays high for exactly CLR_CYCLES cycles. On the last of these edges:
  - ctr_reset<=0.
  - If target!=0: T<=1, go to RUN.
  - If target==0: go to SETTLE with T=0.
- RUN: each rising edge with T=1 is one counter increment; shadow<=shadow+1.
  - If shadow+1==target: T<=0, go to SETTLE. This has priority over pause.
  - Else if pause=1: T<=0, go to PAUSED. The increment at this edge still counts.
  - Result: T is high for exactly `target` rising edges per run, excluding paused time.
- PAUSED: T=0, shadow holds. An edge with pause=0 sets T<=1 and returns to RUN.
- SETTLE: T=0 for SETTLE cycles. On the last of these edges:
  - count<=q.
  - error<=(q!=shadow).
  - done<=1 for one cycle.
  - Go to IDLE.
- abort=1 at an edge in any non-IDLE state: T<=0, ctr_reset<=0, go to IDLE. No done; count and error unchanged. abort outranks all other transitions. abort in IDLE has no effect.
- Shadow is WIDTH bits. The maximum target is 2^WIDTH-1, so no wrap occurs within a run; target=31 with WIDTH=5 ends with q=31.
- Simultaneous start and abort in IDLE: start is accepted (abort only acts outside IDLE).
- Reset mid-run: outputs return to reset values asynchronously. The counter is left uncleared; the next start clears it through CLEAR.
- Latency, start to first enabled edge: CLR_CYCLES+1 edges. Last enabled edge to done: SETTLE edges.

Test Plan:
- target=10, no pause → ctr_reset high 2 cycles; T high for exactly 10 edges; done pulse 3 cycles after the last enabled edge; count=10, error=0, busy low after done.
- target=20, pause held 5 cycles after the 4th enabled edge → T low during the pause; total T-high edges=20; count=20, error=0.
- target=0 → T never asserts; done after CLEAR+SETTLE (6 edges after start); count=0.
- target=31 (max) → count=31, error=0. Then a counter model that drops one increment (target=12) → count=11, error=1. The next start clears error to 0.
- abort at the 6th enabled edge of a target=15 run → T=0 next cycle; no done; busy=0; a start pulse during the run before abort is ignored.
- Async reset asserted mid-RUN between clock edges → T, ctr_reset, busy drop immediately. After release, target=7 runs cleanly to count=7.
